// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller back-end definitions: request sizing, DDR column
// timing defaults and the common bank-group / issue-state types.
package mem_ctrl_pkg;

  localparam int REQ_SIZE   = 32;
  localparam int NUM_BG     = 4;
  localparam int MAX_BURSTS = 4;
  localparam int TCCD_S     = 2;
  localparam int TCCD_L     = 4;

  typedef logic [1:0] bg_idx_t;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_DRAIN = 2'd1,
    ISS_DONE  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/bg_cmd_issue_if.sv
// Bank-group request queues on one side, PHY-side command port on the other.
// master = the issuing block, slave = queues plus command encoder.
interface bg_cmd_issue_if #(
  parameter int REQ_SIZE = mem_ctrl_pkg::REQ_SIZE
);

  logic [mem_ctrl_pkg::NUM_BG-1:0]          req_valid_i;
  logic [mem_ctrl_pkg::NUM_BG*REQ_SIZE-1:0] req_data_i;
  logic [mem_ctrl_pkg::NUM_BG-1:0]          req_pop_o;
  logic                                     cmd_valid_o;
  logic [REQ_SIZE-1:0]                      cmd_data_o;
  mem_ctrl_pkg::bg_idx_t                    cmd_bg_o;
  logic                                     cmd_ready_i;

  modport master (
    input  req_valid_i, req_data_i, cmd_ready_i,
    output req_pop_o, cmd_valid_o, cmd_data_o, cmd_bg_o
  );

  modport slave (
    output req_valid_i, req_data_i, cmd_ready_i,
    input  req_pop_o, cmd_valid_o, cmd_data_o, cmd_bg_o
  );

endinterface

// File: rtl/ccd_gap_timer.sv
// Loadable down-counter with a zero flag; spaces column commands and is meant
// to be reused for the row-to-row and four-activate windows.
module ccd_gap_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bg_cmd_issue.sv
// Drains the granted bank-group queue onto a registered valid/ready command
// port, enforcing tCCD_S / tCCD_L spacing and a per-grant burst quota.
module bg_cmd_issue #(
  parameter int REQ_SIZE   = mem_ctrl_pkg::REQ_SIZE,
  parameter int MAX_BURSTS = mem_ctrl_pkg::MAX_BURSTS,
  parameter int TCCD_S     = mem_ctrl_pkg::TCCD_S,
  parameter int TCCD_L     = mem_ctrl_pkg::TCCD_L
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  grant_i,
  input  logic [$clog2(MAX_BURSTS):0] num_bursts_i,
  bg_cmd_issue_if.master              bus,
  output logic                        burst_done_o,
  output logic                        grant_err_o
);

  import mem_ctrl_pkg::*;

  localparam int CNT_W = $clog2(MAX_BURSTS) + 1;
  localparam int GAP_W = $clog2(TCCD_L + 1);

  localparam logic [1:0] IDLE  = ISS_IDLE;
  localparam logic [1:0] DRAIN = ISS_DRAIN;
  localparam logic [1:0] DONE  = ISS_DONE;

  logic [1:0]          state_q, state_d;
  bg_idx_t             bg_q, bg_d;
  logic [CNT_W-1:0]    quota_q, quota_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    count_inc;
  logic [CNT_W-1:0]    quota_new;
  bg_idx_t             last_bg_q;
  logic                last_vld_q;
  logic                grant_vld;
  bg_idx_t             grant_bg;
  logic                grant_bad;
  logic                gap_zero;
  logic [GAP_W-1:0]    gap_load;
  logic                issue;
  logic [REQ_SIZE-1:0] issue_data;

  logic                cmd_vld_p1;
  logic [REQ_SIZE-1:0] cmd_data_p1;
  bg_idx_t             cmd_bg_p1;
  logic                burst_done_q;
  logic                grant_err_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_bg  = '0;
    case (grant_i)
      4'b0001: begin grant_vld = 1'b1; grant_bg = 2'd0; end
      4'b0010: begin grant_vld = 1'b1; grant_bg = 2'd1; end
      4'b0100: begin grant_vld = 1'b1; grant_bg = 2'd2; end
      4'b1000: begin grant_vld = 1'b1; grant_bg = 2'd3; end
      default: begin grant_vld = 1'b0; grant_bg = '0;   end
    endcase
  end

  assign grant_bad = (grant_i != 4'b0000) && !grant_vld;
  assign quota_new = (num_bursts_i == '0) ? CNT_W'(MAX_BURSTS) : num_bursts_i;
  assign count_inc = count_q + CNT_W'(1);

  // A grant that moved this cycle is relatched first; issue resumes next cycle.
  assign issue = (state_q == DRAIN) && grant_vld && (grant_bg == bg_q) &&
                 bus.req_valid_i[bg_q] && gap_zero &&
                 (!cmd_vld_p1 || bus.cmd_ready_i) && (count_q < quota_q);

  assign issue_data    = bus.req_data_i[bg_q*REQ_SIZE +: REQ_SIZE];
  assign bus.req_pop_o = issue ? (4'b0001 << bg_q) : 4'b0000;

  // Spacing after this issue keys off whether it repeated the previous bank group.
  assign gap_load = (last_vld_q && (last_bg_q == bg_q)) ? GAP_W'(TCCD_L - 1)
                                                       : GAP_W'(TCCD_S - 1);

  ccd_gap_timer #(.CNT_W(GAP_W)) u_ccd_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue),
    .load_val (gap_load),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    quota_d = quota_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = DRAIN;
          bg_d    = grant_bg;
          quota_d = quota_new;
          count_d = '0;
        end
      end
      DRAIN: begin
        if (!grant_vld) begin
          state_d = IDLE;
        end else if (grant_bg != bg_q) begin
          bg_d    = grant_bg;
          quota_d = quota_new;
          count_d = '0;
        end else if (issue) begin
          count_d = count_inc;
          if (count_inc == quota_q) state_d = DONE;
        end else if (!bus.req_valid_i[bg_q]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!grant_vld) begin
          state_d = IDLE;
        end else if (grant_bg != bg_q) begin
          state_d = DRAIN;
          bg_d    = grant_bg;
          quota_d = quota_new;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered command slot and control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bg_q         <= '0;
      quota_q      <= '0;
      count_q      <= '0;
      last_bg_q    <= '0;
      last_vld_q   <= 1'b0;
      cmd_vld_p1   <= 1'b0;
      cmd_data_p1  <= '0;
      cmd_bg_p1    <= '0;
      burst_done_q <= 1'b0;
      grant_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bg_q         <= bg_d;
      quota_q      <= quota_d;
      count_q      <= count_d;
      burst_done_q <= (state_d == DONE) && (state_q != DONE);
      grant_err_q  <= grant_err_q | grant_bad;
      if (issue) begin
        cmd_vld_p1  <= 1'b1;
        cmd_data_p1 <= issue_data;
        cmd_bg_p1   <= bg_q;
        last_bg_q   <= bg_q;
        last_vld_q  <= 1'b1;
      end else if (bus.cmd_ready_i) begin
        cmd_vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.cmd_valid_o = cmd_vld_p1;
  assign bus.cmd_data_o  = cmd_data_p1;
  assign bus.cmd_bg_o    = cmd_bg_p1;
  assign burst_done_o    = burst_done_q;
  assign grant_err_o     = grant_err_q;

endmodule

// File: tb/tb_bg_cmd_issue.sv
// Bench for bg_cmd_issue: directed reset/latency/spacing/stall/dry-queue/error
// sequences, a table-driven quota drain, and a randomized run against a model.
module tb_bg_cmd_issue;

  localparam int RS = 32;
  localparam int MB = 4;
  localparam int TS = 2;
  localparam int TL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] grant;
  logic [2:0] nb;
  logic       burst_done;
  logic       grant_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  bg_cmd_issue_if #(.REQ_SIZE(RS)) bus ();

  bg_cmd_issue #(.REQ_SIZE(RS), .MAX_BURSTS(MB), .TCCD_S(TS), .TCCD_L(TL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_i      (grant),
    .num_bursts_i (nb),
    .bus          (bus),
    .burst_done_o (burst_done),
    .grant_err_o  (grant_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [2:0] nb;
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] pop;
    logic       cvld;
    logic       done;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic [3:0] g, input logic p, input logic v, input logic d);
    vec_t t;
    t.grant = g; t.nb = 3'd3; t.rv = 4'b0001; t.rdy = 1'b1;
    t.pop = {3'b000, p}; t.cvld = v; t.done = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] g, input logic [2:0] n,
                       input logic [3:0] rv, input logic rdy);
    rst_n = r; grant = g; nb = n; bus.req_valid_i = rv; bus.cmd_ready_i = rdy;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 3'd0, 4'b0000, 1'b1);
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] DATA0 = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, dones;
    logic [3:0] g, rv;
    logic [2:0] n;
    logic r, rdy, oh, can, nd;
    int gi, q;
    bit m_act, m_fin, m_has_last, m_cvld, m_done, m_err;
    int m_bg, m_quota, m_iss, m_next, m_last_bg, m_cbg;
    logic [31:0] m_cdata;

    tbl[0]  = mk(4'b0001, 0, 0, 0);
    tbl[1]  = mk(4'b0001, 1, 0, 0);
    tbl[2]  = mk(4'b0001, 0, 1, 0);
    tbl[3]  = mk(4'b0001, 0, 0, 0);
    tbl[4]  = mk(4'b0001, 0, 0, 0);
    tbl[5]  = mk(4'b0001, 1, 0, 0);
    tbl[6]  = mk(4'b0001, 0, 1, 0);
    tbl[7]  = mk(4'b0001, 0, 0, 0);
    tbl[8]  = mk(4'b0001, 0, 0, 0);
    tbl[9]  = mk(4'b0001, 1, 0, 0);
    tbl[10] = mk(4'b0001, 0, 1, 1);
    tbl[11] = mk(4'b0001, 0, 0, 0);
    tbl[12] = mk(4'b0000, 0, 0, 0);

    // Reset held with a live grant: everything stays at zero
    drive(1'b0, 4'b0001, 3'd1, 4'b0001, 1'b1);
    bus.req_data_i = DATA0;
    nxt();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst_pop", bus.req_pop_o, 0);
      chk("rst_cvld", bus.cmd_valid_o, 0);
      chk("rst_cdata", bus.cmd_data_o, 0);
      chk("rst_cbg", bus.cmd_bg_o, 0);
      chk("rst_done", burst_done, 0);
      chk("rst_err", grant_err, 0);
      nxt();
    end
    rst_n = 1'b1;
    mid(); chk("lat_pop_c0", bus.req_pop_o, 4'b0000); nxt();
    mid(); chk("lat_pop_c1", bus.req_pop_o, 4'b0001); nxt();
    mid();
    chk("lat_cvld", bus.cmd_valid_o, 1);
    chk("lat_cdata", bus.cmd_data_o, 32'hA0A0_0000);
    chk("lat_cbg", bus.cmd_bg_o, 0);
    chk("lat_done", burst_done, 1);
    chk("lat_pop_c2", bus.req_pop_o, 0);
    nxt();
    grant = 4'b0000;
    mid(); chk("lat_cvld_fall", bus.cmd_valid_o, 0); chk("lat_done_once", burst_done, 0); nxt();
    mid(); nxt();

    // Quota of 3 on A, previous issue was also A: tCCD_L spacing
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].grant, tbl[i].nb, tbl[i].rv, tbl[i].rdy);
      mid();
      chk($sformatf("tbl%0d_pop", i), bus.req_pop_o, tbl[i].pop);
      chk($sformatf("tbl%0d_cvld", i), bus.cmd_valid_o, tbl[i].cvld);
      chk($sformatf("tbl%0d_done", i), burst_done, tbl[i].done);
      if (tbl[i].cvld) chk($sformatf("tbl%0d_cdata", i), bus.cmd_data_o, 32'hA0A0_0000);
      nxt();
    end

    // A then B, one burst each: tCCD_S spacing between groups
    do_reset();
    drive(1'b1, 4'b0001, 3'd1, 4'b0011, 1'b1);
    mid(); chk("ab_pop_r0", bus.req_pop_o, 4'b0000); nxt();
    mid(); chk("ab_pop_a", bus.req_pop_o, 4'b0001); nxt();
    grant = 4'b0010;
    mid();
    chk("ab_pop_r2", bus.req_pop_o, 4'b0000);
    chk("ab_cbg_a", bus.cmd_bg_o, 0);
    chk("ab_done_a", burst_done, 1);
    nxt();
    mid(); chk("ab_pop_b", bus.req_pop_o, 4'b0010); nxt();
    mid();
    chk("ab_cbg_b", bus.cmd_bg_o, 1);
    chk("ab_cvld_b", bus.cmd_valid_o, 1);
    chk("ab_cdata_b", bus.cmd_data_o, 32'hB1B1_0001);
    chk("ab_done_b", burst_done, 1);
    nxt();

    // Downstream stall: command held, no pops, release pops same cycle
    do_reset();
    drive(1'b1, 4'b0001, 3'd4, 4'b0001, 1'b1);
    mid(); nxt();
    mid(); chk("stall_pop0", bus.req_pop_o, 4'b0001); nxt();
    bus.cmd_ready_i = 1'b0;
    bus.req_data_i[31:0] = 32'h5555_AAAA;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("stall_cvld", bus.cmd_valid_o, 1);
      chk("stall_cdata", bus.cmd_data_o, 32'hA0A0_0000);
      chk("stall_pop", bus.req_pop_o, 0);
      nxt();
    end
    bus.cmd_ready_i = 1'b1;
    mid(); chk("stall_release_pop", bus.req_pop_o, 4'b0001); nxt();
    mid(); chk("stall_new_cdata", bus.cmd_data_o, 32'h5555_AAAA); chk("stall_new_cvld", bus.cmd_valid_o, 1); nxt();
    bus.req_data_i = DATA0;

    // C runs dry after two issues
    do_reset();
    pops = 0; dones = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'b0100, 3'd4, (k == 4) ? 4'b0000 : 4'b0100, 1'b1);
      mid();
      pops += int'(bus.req_pop_o[2]);
      dones += int'(burst_done);
      if (k == 4) chk("dry_no_pop", bus.req_pop_o, 0);
      nxt();
    end
    chk("dry_pops", pops, 2);
    chk("dry_done_cnt", dones, 1);

    // Non-one-hot grant: sticky error, then quota 0 means MAX_BURSTS
    do_reset();
    drive(1'b1, 4'b0110, 3'd2, 4'b1111, 1'b1);
    mid(); chk("err_pre", grant_err, 0); chk("err_pop0", bus.req_pop_o, 0); nxt();
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("err_set", grant_err, 1);
      chk("err_pop", bus.req_pop_o, 0);
      chk("err_cvld", bus.cmd_valid_o, 0);
      nxt();
    end
    grant = 4'b0000;
    nxt();
    drive(1'b1, 4'b0001, 3'd0, 4'b0001, 1'b1);
    pops = 0;
    for (int k = 0; k < 24; k++) begin
      mid(); pops += int'(bus.req_pop_o[0]); nxt();
    end
    chk("q0_pops", pops, MB);
    chk("err_sticky", grant_err, 1);
    do_reset();
    mid(); chk("err_cleared", grant_err, 0); nxt();

    // Randomized run against the behavioural model
    m_act = 0; m_fin = 0; m_bg = 0; m_quota = 0; m_iss = 0; m_next = 0;
    m_has_last = 0; m_last_bg = 0; m_cvld = 0; m_cdata = '0; m_cbg = 0; m_done = 0; m_err = 0;
    g = 4'b0000; n = 3'd0;
    for (int c = 0; c < 3000; c++) begin
      r = !(c < 2 || $urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        int sel;
        sel = $urandom_range(0, 19);
        if (sel < 3)       g = 4'b0000;
        else if (sel == 19) g = 4'b1001;
        else               g = 4'b0001 << $urandom_range(0, 3);
        n = 3'($urandom_range(0, 4));
      end
      rv  = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 9) < 7);
      drive(r, g, n, rv, rdy);
      bus.req_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};

      oh = $onehot(g);
      gi = 0;
      for (int b = 0; b < 4; b++) if (g[b]) gi = b;
      q = (n == 0) ? MB : int'(n);
      can = m_act && !m_fin && oh && (gi == m_bg) && rv[m_bg] && (c >= m_next) &&
            (!m_cvld || rdy) && (m_iss < m_quota);

      mid();
      chk("rnd_pop", bus.req_pop_o, can ? (64'd1 << m_bg) : 64'd0);
      chk("rnd_cvld", bus.cmd_valid_o, m_cvld);
      chk("rnd_cdata", bus.cmd_data_o, m_cdata);
      chk("rnd_cbg", bus.cmd_bg_o, m_cbg);
      chk("rnd_done", burst_done, m_done);
      chk("rnd_err", grant_err, m_err);

      if (!r) begin
        m_act = 0; m_fin = 0; m_bg = 0; m_quota = 0; m_iss = 0; m_next = 0;
        m_has_last = 0; m_last_bg = 0; m_cvld = 0; m_cdata = '0; m_cbg = 0; m_done = 0; m_err = 0;
      end else begin
        nd = 0;
        if (can) begin
          m_cdata = bus.req_data_i[m_bg*32 +: 32];
          m_cbg = m_bg;
          m_cvld = 1;
          m_next = c + ((m_has_last && m_last_bg == m_bg) ? TL : TS);
          m_has_last = 1;
          m_last_bg = m_bg;
          m_iss++;
        end else if (rdy) begin
          m_cvld = 0;
        end
        if (g != 4'b0000 && !oh) m_err = 1;
        if (!m_act) begin
          if (oh) begin m_act = 1; m_fin = 0; m_bg = gi; m_quota = q; m_iss = 0; end
        end else if (!oh) begin
          m_act = 0;
        end else if (gi != m_bg) begin
          m_fin = 0; m_bg = gi; m_quota = q; m_iss = 0;
        end else if (!m_fin && ((can && m_iss == m_quota) || (!can && !rv[m_bg]))) begin
          m_fin = 1; nd = 1;
        end
        m_done = nd;
      end
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bg_cmd_issue.md
Name: bg_cmd_issue

Overview:
- Sits directly downstream of the bank-group arbiter in the back-end.
- Takes the arbiter's one-hot grant, pops requests from the granted bank-group queue and enforces DDR column spacing: tCCD_L for the same bank group, tCCD_S for a different one.
- Presents the requests one at a time on a registered valid/ready command port to the PHY-side command encoder.
- Counts bursts per grant and pulses burst_done_o so the arbiter can rotate to the next bank group.

Parameters:
- REQ_SIZE, 32, width of one request word (address + command + tag).
- MAX_BURSTS, 4, upper bound on bursts drained per grant.
- TCCD_S, 2, minimum cycles between issues to different bank groups (≥1).
- TCCD_L, 4, minimum cycles between issues to the same bank group (≥TCCD_S).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- grant_i  in  4  one-hot grant from the arbiter; bit0=A … bit3=D.
- num_bursts_i  in  $clog2(MAX_BURSTS)+1  burst quota per grant; 0 means MAX_BURSTS.
- req_valid_i  in  4  per-bank-group queue non-empty.
- req_data_i  in  4*REQ_SIZE  head-of-queue words; slice g = bank group g.
- req_pop_o  out  4  one-cycle pop to the bank-group queue (combinational).
- cmd_valid_o  out  1  command output valid (registered).
- cmd_data_o  out  REQ_SIZE  command word (registered).
- cmd_bg_o  out  2  bank-group index of cmd_data_o (registered).
- cmd_ready_i  in  1  downstream accepts when high together with cmd_valid_o.
- burst_done_o  out  1  one-cycle pulse: quota met or granted queue ran dry.
- grant_err_o  out  1  sticky: grant_i was non-zero and not one-hot.

Behaviour:
- Reset values:
  - cmd_valid_o=0, cmd_data_o=0, cmd_bg_o=0.
  - burst_done_o=0, grant_err_o=0, req_pop_o=0.
  - burst counter=0, gap counter=0, last_bg=0, last_valid=0, state IDLE.
- Grant decode:
  - grant_i one-hot → g = index.
  - grant_i zero → no grant.
  - Any other value → treated as no grant, and grant_err_o sets on the next edge; it clears only on reset.
- States:
  - IDLE: no grant.
  - DRAIN: issuing from g.
  - DONE: quota met; wait for grant change.
- Transitions:
  - IDLE→DRAIN when a valid grant appears. On entry, latch quota q = (num_bursts_i==0 ? MAX_BURSTS : num_bursts_i) and clear the burst counter.
  - DRAIN→DONE on the edge where the issue makes count==q.
  - DRAIN→DONE when req_valid_i[g]==0 and no issue occurs in that cycle.
  - DONE→IDLE when grant_i becomes zero.
  - DONE→DRAIN directly when grant_i changes to a different one-hot value, with a new q latched.
- Grant change while in DRAIN: counter cleared, q relatched, stays in DRAIN with the new g, no burst_done_o pulse.
- burst_done_o: asserted for exactly the cycle after entering DONE, once per entry.
- Issue condition, all in one cycle:
  - state DRAIN;
  - req_valid_i[g]=1;
  - gap counter==0;
  - output slot free, meaning cmd_valid_o==0 or cmd_ready_i==1.
- On issue:
  - req_pop_o[g]=1 in that same cycle.
  - Next edge: cmd_data_o ← slice g, cmd_bg_o ← g, cmd_valid_o ← 1, count++.
  - Gap counter ← (last_valid && last_bg==g) ? TCCD_L-1 : TCCD_S-1.
  - Then last_bg ← g, last_valid ← 1.
- Gap counter decrements by 1 per cycle while non-zero, independent of state. Back-to-back issue to the same bank group therefore occurs every TCCD_L cycles.
- Output handshake:
  - cmd_valid_o falls when cmd_ready_i=1 and no new issue occurs.
  - cmd_data_o holds stable while cmd_valid_o=1 and cmd_ready_i=0.
- Latency: grant + valid with gap 0 → cmd_valid_o high 1 cycle later.
- Counter saturates at q; no wrap.
- Reset mid-drain: every output and register returns to its reset value on that edge; any in-flight cmd is dropped.
- num_bursts_i changes during a grant are ignored until the next grant.

Decomposition:
- Shared package (mem_ctrl_pkg):
  - REQ_SIZE, NUM_BG=4, MAX_BURSTS;
  - tCCD_S/tCCD_L defaults;
  - bg_idx_t (2-bit);
  - an issue-state enum.
- One natural sub-module: ccd_gap_timer, a loadable down-counter with a zero flag, reused by later tRRD/tFAW checks.

Test Plan:
- Reset with grant_i=0001, req_valid_i=0001 held → all outputs 0 throughout; first issue 2 cycles after rst_n rises (state IDLE→DRAIN, then issue).
- grant=0001, num_bursts_i=3, req_valid A high, cmd_ready_i=1, TCCD_L=4 → req_pop_o[0] at t0, t4, t8; burst_done_o pulses at t9; no further pops.
- Grant A then B, one burst each, TCCD_S=2 → B's pop occurs 2 cycles after A's pop, not 4; cmd_bg_o sequence 0,1.
- cmd_ready_i=0 for 5 cycles with cmd_valid_o=1 → cmd_data_o constant, no pops; cmd_ready_i=1 → next pop the same cycle (gap expired).
- grant=0100, num_bursts_i=4, req_valid C drops after 2 issues → burst_done_o pulses once; count 2; no pop while valid is low.
- grant_i=0110 → no pops, cmd_valid_o stays 0, grant_err_o=1 next cycle and remains 1 until rst_n=0; num_bursts_i=0 on a later grant → 4 bursts issued.
